execute_unit: RTL and testbench

Single-issue 8-bit execute stage sitting directly downstream of the register file. It consumes the two register read operands plus a decoded opcode and destination address, and computes the ALU result. It drives the register file's write port (enable, address, data) and maintains a 4-bit status flag register. Most operations complete in one cycle; an optional shift-add multiplier takes eight cycles.

---
 rtl/execute_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_execute_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// execute_unit: 8-bit single-issue execute stage placed directly after the
// register file. It computes the ALU result, drives the register-file write
// port and keeps a registered {Z, N, C, V} flag vector.
// Optional feature macro: EXECUTE_UNIT_MUL_EN. When defined, opcode A runs an
// 8-step shift-add multiply and the stage reports busy while it runs. When
// undefined, opcode A is decoded as illegal and the stage never stalls.
module execute_unit #(
    parameter int WIDTH     = 8,
    parameter int MUL_STEPS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       dest_addr,
    output logic             wb_enable,
    output logic [2:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             illegal_op
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
`ifdef EXECUTE_UNIT_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hA;
`endif

    // The multiplier retires exactly one operand bit per step.
    if ((MUL_STEPS != WIDTH) || (WIDTH != 8)) begin : g_bad_config
        $error("execute_unit: only WIDTH = MUL_STEPS = 8 is supported");
    end

    // Flag vector {Z, N, C, V} for a result and its carry/overflow bits.
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic             c,
                                              input logic             v);
        make_flags = {(res == {WIDTH{1'b0}}), res[MSB], c, v};
    endfunction

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             ovf_s;
    logic             legal_s;
    logic             writes_s;
    logic             flag_upd_s;
    logic             accept_s;

    logic             wb_enable_r;
    logic [2:0]       wb_addr_r;
    logic [WIDTH-1:0] wb_data_r;
    logic [3:0]       flags_r;
    logic             illegal_r;

    // Extra top bit holds the carry of the add and the borrow of the subtract.
    assign sum_s  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff_s = {1'b0, operand_a} - {1'b0, operand_b};

`ifdef EXECUTE_UNIT_MUL_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int                STEP_W    = $clog2(MUL_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

    state_t               state_r;
    logic                 busy_r;
    logic                 is_mul_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]     mplier_r;
    logic [STEP_W-1:0]    step_r;
    logic [2:0]           mul_dest_r;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign in_ready   = rst && (state_r == ST_IDLE);
    assign busy       = busy_r;
`else
    assign in_ready   = rst;
    assign busy       = 1'b0;
`endif

    assign accept_s = in_valid && in_ready;

    // Decode the opcode into a result, carry/overflow and writeback intent.
    always_comb begin
        result_s   = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        ovf_s      = 1'b0;
        legal_s    = 1'b1;
        writes_s   = 1'b1;
        flag_upd_s = 1'b1;
`ifdef EXECUTE_UNIT_MUL_EN
        is_mul_s   = 1'b0;
`endif
        case (op)
            OP_ADD: begin
                result_s = sum_s[MSB:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (operand_a[MSB] == operand_b[MSB]) && (sum_s[MSB] != operand_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                result_s = diff_s[MSB:0];
                carry_s  = diff_s[WIDTH];
                ovf_s    = (operand_a[MSB] != operand_b[MSB]) && (diff_s[MSB] != operand_a[MSB]);
                writes_s = (op == OP_SUB);
            end
            OP_AND: result_s = operand_a & operand_b;
            OP_OR:  result_s = operand_a | operand_b;
            OP_XOR: result_s = operand_a ^ operand_b;
            OP_NOT: result_s = ~operand_a;
            OP_SHL: begin
                result_s = {operand_a[MSB-1:0], 1'b0};
                carry_s  = operand_a[MSB];
            end
            OP_SHR: begin
                result_s = {1'b0, operand_a[MSB:1]};
                carry_s  = operand_a[0];
            end
            OP_MOV: result_s = operand_b;
`ifdef EXECUTE_UNIT_MUL_EN
            OP_MUL: begin
                // Result and flags are produced by the sequencer at the last step.
                is_mul_s   = 1'b1;
                writes_s   = 1'b0;
                flag_upd_s = 1'b0;
            end
`endif
            default: begin
                legal_s    = 1'b0;
                writes_s   = 1'b0;
                flag_upd_s = 1'b0;
            end
        endcase
    end

    // Writeback port, flags, illegal pulse and multiply sequencing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_enable_r <= 1'b0;
            wb_addr_r   <= 3'd0;
            wb_data_r   <= {WIDTH{1'b0}};
            flags_r     <= 4'h0;
            illegal_r   <= 1'b0;
`ifdef EXECUTE_UNIT_MUL_EN
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            mcand_r     <= {(2*WIDTH){1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            step_r      <= {STEP_W{1'b0}};
            mul_dest_r  <= 3'd0;
`endif
        end else begin
            wb_enable_r <= 1'b0;
            illegal_r   <= 1'b0;
            if (accept_s) begin
                illegal_r <= !legal_s;
                if (flag_upd_s) begin
                    flags_r <= make_flags(result_s, carry_s, ovf_s);
                end
                if (writes_s) begin
                    wb_enable_r <= 1'b1;
                    wb_addr_r   <= dest_addr;
                    wb_data_r   <= result_s;
                end
            end
`ifdef EXECUTE_UNIT_MUL_EN
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        mcand_r    <= {{WIDTH{1'b0}}, operand_a};
                        mplier_r   <= operand_b;
                        acc_r      <= {(2*WIDTH){1'b0}};
                        step_r     <= {STEP_W{1'b0}};
                        mul_dest_r <= dest_addr;
                        busy_r     <= 1'b1;
                        state_r    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[MSB:1]};
                    step_r   <= step_r + STEP_W'(1'b1);
                    if (step_r == LAST_STEP) begin
                        wb_enable_r <= 1'b1;
                        wb_addr_r   <= mul_dest_r;
                        wb_data_r   <= acc_next_s[MSB:0];
                        flags_r     <= make_flags(acc_next_s[MSB:0],
                                                  |acc_next_s[2*WIDTH-1:WIDTH], 1'b0);
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
`endif
        end
    end

    assign wb_enable  = wb_enable_r;
    assign wb_addr    = wb_addr_r;
    assign wb_data    = wb_data_r;
    assign flags      = flags_r;
    assign illegal_op = illegal_r;

endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: scoreboard bench for execute_unit. The driver predicts each
// accepted operation with an arithmetic reference model and queues the
// expected response; the monitor compares DUT outputs every cycle.
module tb_execute_unit;

`ifdef EXECUTE_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       in_valid  = 1'b0;
    logic [3:0] op        = 4'h0;
    logic [7:0] operand_a = 8'h00;
    logic [7:0] operand_b = 8'h00;
    logic [2:0] dest_addr = 3'd0;
    logic       in_ready;
    logic       wb_enable;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic [3:0] flags;
    logic       busy;
    logic       illegal_op;

    execute_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_addr  (dest_addr),
        .wb_enable  (wb_enable),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags      (flags),
        .busy       (busy),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         is_write;
        bit         is_illegal;
        logic [2:0] addr;
        logic [7:0] data;
        logic [3:0] flg;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc       = 0;
    int         mul_start = -1;
    int         mul_done  = -1;
    logic [3:0] exp_flags = 4'h0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    // Count edges; edge k leaves cyc == k when sampled after it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: actual %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: result, flags and latency from the opcode rules.
    function automatic void ref_model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                      output bit wr, output bit ill, output logic [7:0] r,
                                      output logic [3:0] f, output int lat);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int full = 0;
        bit c = 1'b0;
        bit v = 1'b0;
        ill = 1'b0;
        lat = 0;
        case (o)
            4'h0: begin full = ua + ub; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'h1, 4'h9: begin full = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'h2: full = ua & ub;
            4'h3: full = ua | ub;
            4'h4: full = ua ^ ub;
            4'h5: full = 255 - ua;
            4'h6: begin full = ua * 2; c = a[7]; end
            4'h7: begin full = ua / 2; c = a[0]; end
            4'h8: full = ub;
            4'hA: begin
                if (MUL_EN) begin full = ua * ub; c = (full > 255); lat = 8; end
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        r  = full[7:0];
        f  = {(r == 8'h00), r[7], c, v};
        wr = !ill && (o != 4'h9);
    endfunction

    // Present one op, hold it until the model says the stage can take it, then predict.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        int waited = 0;
        int e;
        int lat;
        bit wr;
        bit ill;
        logic [7:0] r;
        logic [3:0] f;
        exp_t x;
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; dest_addr = d; in_valid = 1'b1;
        while ((cyc + 1 <= mul_done) && (waited < 20)) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout at edge %0d: actual waited %0d, required < 20", cyc, waited);
            in_valid = 1'b0;
        end else begin
            ref_model(o, a, b, wr, ill, r, f, lat);
            e = cyc + 1;
            if (lat > 0) begin
                mul_start = e;
                mul_done  = e + lat;
            end
            x.due = e + lat; x.is_write = wr; x.is_illegal = ill;
            x.addr = d; x.data = r; x.flg = f;
            sb_q.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // One reset edge; anything in flight is dropped.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        mul_start = -1;
        mul_done  = -1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare every cycle against the queued expectations.
    always @(posedge clk) begin : monitor
        bit   eb;
        exp_t e;
        #1;
        if (!rst) begin
            check_eq("rst_wb_enable", wb_enable, 0);
            check_eq("rst_wb_addr", wb_addr, 0);
            check_eq("rst_wb_data", wb_data, 0);
            check_eq("rst_flags", flags, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_illegal_op", illegal_op, 0);
            check_eq("rst_in_ready", in_ready, 0);
            exp_flags = 4'h0;
        end else begin
            eb = (cyc >= mul_start) && (cyc < mul_done);
            check_eq("busy", busy, eb);
            check_eq("in_ready", in_ready, !eb);
            if ((sb_q.size() > 0) && (sb_q[0].due == cyc)) begin
                e = sb_q.pop_front();
                check_eq("wb_enable", wb_enable, e.is_write);
                check_eq("illegal_op", illegal_op, e.is_illegal);
                if (e.is_write) begin
                    check_eq("wb_addr", wb_addr, e.addr);
                    check_eq("wb_data", wb_data, e.data);
                end
                if (!e.is_illegal) exp_flags = e.flg;
            end else begin
                check_eq("idle_wb_enable", wb_enable, 0);
                check_eq("idle_illegal_op", illegal_op, 0);
            end
            check_eq("flags", flags, exp_flags);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed cases from the test plan.
        issue(4'h0, 8'h7F, 8'h01, 3'd3);
        issue(4'h1, 8'h05, 8'h05, 3'd1);
        issue(4'h9, 8'h02, 8'h03, 3'd2);
        issue(4'h6, 8'h81, 8'h00, 3'd4);
        issue(4'h7, 8'h01, 8'h00, 3'd5);
        issue(4'hA, 8'h13, 8'h11, 3'd6);
        issue(4'h0, 8'h01, 8'h02, 3'd7);
        issue(4'hC, 8'h55, 8'hAA, 3'd1);
        idle(2);

        // Multiply aborted by reset on its fourth step edge.
        issue(4'hA, 8'hFF, 8'hFF, 3'd2);
        idle(3);
        do_reset();
        idle(12);

        // Randomized traffic with gaps and occasional resets.
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        idle(12);
        check_eq("queue_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
